// File: rtl/kovacs_pkg.sv
// Shared encodings for the Kovacs three-level protocol sequencer.
package kovacs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_RESC = 2'd3
  } state_e;

  localparam int IND_HIGH = 8191;
  localparam int IND_RESC = 4096;
  localparam int IND_LOW  = 0;

endpackage

// File: rtl/kovacs_phase_timer.sv
// Phase-duration counter: counts 0..max(dur,1)-1 and flags the terminal count.
module kovacs_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] dur,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last;

  // A zero duration behaves as one cycle; the counter never passes dur-1,
  // so the all-ones duration cannot overflow.
  assign last = (dur == '0) ? '0 : dur - CNT_W'(1);
  assign tc   = en && (cnt_q == last);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)  cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/kovacs_sequencer.sv
// Run-controlled HIGH -> LOW -> RESC sequencer driving the DAC sample and phase marker.
module kovacs_sequencer
  import kovacs_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REP_W  = 16,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 14
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  T0_i,
  input  logic [CNT_W-1:0]  T1_i,
  input  logic [CNT_W-1:0]  T2_i,
  input  logic [REP_W-1:0]  reps_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] data_rescaled_i,
  input  logic [DATA_W-1:0] data_low_i,
  output logic [OUT_W-1:0]  data_o,
  output logic [OUT_W-1:0]  indicator_o,
  output logic [1:0]        phase_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [REP_W-1:0]  cycle_cnt_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t0_q, t1_q, t2_q, cur_dur;
  logic [REP_W-1:0] reps_q, cyc_q, cyc_nxt;
  logic             cap, cyc_inc, done_d, done_q, tc;
  logic             run;
  logic [OUT_W-1:0] data_q, ind_q;
  logic             unused_lsbs;

  assign unused_lsbs = ^{data_i[DATA_W-OUT_W-1:0], data_rescaled_i[DATA_W-OUT_W-1:0],
                         data_low_i[DATA_W-OUT_W-1:0]};

  assign run     = (state_q != ST_IDLE);
  assign cyc_nxt = cyc_q + REP_W'(1);

  // RESC uses T1, LOW uses T2.
  always_comb begin
    cur_dur = t0_q;
    unique case (state_q)
      ST_LOW:  cur_dur = t2_q;
      ST_RESC: cur_dur = t1_q;
      default: cur_dur = t0_q;
    endcase
  end

  kovacs_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr    (!run),
    .en     (run),
    .dur    (cur_dur),
    .tc     (tc)
  );

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    cyc_inc = 1'b0;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start_i && !abort_i) begin
        cap     = 1'b1;
        state_d = ST_HIGH;
      end
    end else if (abort_i) begin
      state_d = ST_IDLE;
    end else if (tc) begin
      unique case (state_q)
        ST_HIGH: state_d = ST_LOW;
        ST_LOW:  state_d = ST_RESC;
        ST_RESC: begin
          cyc_inc = 1'b1;
          if (reps_q != '0 && cyc_nxt == reps_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HIGH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      reps_q  <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (cap) begin
        t0_q   <= T0_i;
        t1_q   <= T1_i;
        t2_q   <= T2_i;
        reps_q <= reps_i;
        cyc_q  <= '0;
      end else if (cyc_inc) begin
        cyc_q  <= cyc_nxt;
      end
    end
  end

  // Sample and marker lag phase_o by one cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q <= '0;
      ind_q  <= '0;
    end else begin
      unique case (state_q)
        ST_HIGH: begin
          data_q <= data_i[DATA_W-1 -: OUT_W];
          ind_q  <= OUT_W'(IND_HIGH);
        end
        ST_LOW: begin
          data_q <= data_low_i[DATA_W-1 -: OUT_W];
          ind_q  <= OUT_W'(IND_LOW);
        end
        ST_RESC: begin
          data_q <= data_rescaled_i[DATA_W-1 -: OUT_W];
          ind_q  <= OUT_W'(IND_RESC);
        end
        default: begin
          data_q <= data_i[DATA_W-1 -: OUT_W];
          ind_q  <= '0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign indicator_o = ind_q;
  assign phase_o     = state_q;
  assign busy_o      = run;
  assign done_o      = done_q;
  assign cycle_cnt_o = cyc_q;

endmodule

// File: tb/tb_kovacs_sequencer.sv
// Bench for kovacs_sequencer: cycle-level countdown model plus directed and random runs.
module tb_kovacs_sequencer;

  logic        clk_i = 1'b0, rstn_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic [31:0] T0_i = '0, T1_i = '0, T2_i = '0;
  logic [15:0] reps_i = '0, data_i = '0, data_rescaled_i = '0, data_low_i = '0;
  logic [13:0] data_o, indicator_o;
  logic [1:0]  phase_o;
  logic        busy_o, done_o;
  logic [15:0] cycle_cnt_o;

  kovacs_sequencer dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .T0_i(T0_i), .T1_i(T1_i), .T2_i(T2_i), .reps_i(reps_i),
    .data_i(data_i), .data_rescaled_i(data_rescaled_i), .data_low_i(data_low_i),
    .data_o(data_o), .indicator_o(indicator_o), .phase_o(phase_o),
    .busy_o(busy_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase number, cycles remaining in the phase, completed cycles.
  int      m_ph = 0, m_cyc = 0, m_reps = 0;
  longint  m_rem = 0;
  longint  d[4];
  bit      m_done = 0;
  int      e_data = 0, e_ind = 0;

  function automatic longint eff(input logic [31:0] t);
    return (t == 0) ? 64'd1 : longint'(t);
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_ph = 0; m_rem = 0; m_cyc = 0; m_done = 0; e_data = 0; e_ind = 0;
    end else begin
      case (m_ph)
        2:       e_data = int'(data_low_i[15:2]);
        3:       e_data = int'(data_rescaled_i[15:2]);
        default: e_data = int'(data_i[15:2]);
      endcase
      e_ind  = (m_ph == 1) ? 8191 : (m_ph == 3) ? 4096 : 0;
      m_done = 0;
      if (m_ph == 0) begin
        if (start_i && !abort_i) begin
          d[1] = eff(T0_i); d[2] = eff(T2_i); d[3] = eff(T1_i);
          m_reps = int'(reps_i); m_cyc = 0; m_ph = 1; m_rem = d[1];
        end
      end else if (abort_i) begin
        m_ph = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_ph == 3) begin
            m_cyc = (m_cyc + 1) % 65536;
            if (m_reps != 0 && m_cyc == m_reps) begin
              m_ph = 0; m_done = 1;
            end else begin
              m_ph = 1; m_rem = d[1];
            end
          end else begin
            m_ph++;
            m_rem = d[m_ph];
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("phase_o", phase_o, m_ph);
    check("busy_o", busy_o, m_ph != 0);
    check("done_o", done_o, m_done);
    check("cycle_cnt_o", cycle_cnt_o, m_cyc);
    check("data_o", data_o, e_data);
    check("indicator_o", indicator_o, e_ind);
  end

  always @(negedge clk_i) begin
    #2;
    data_i          = 16'($urandom);
    data_rescaled_i = 16'($urandom);
    data_low_i      = 16'($urandom);
  end

  int ph_log[64];
  int nlog;

  // Called at negedge+1; pulses start and counts busy/done until the run ends.
  task automatic run_to_idle(input int maxc, input int poke, output int nbusy, output int ndone);
    bit seen = 0;
    int i;
    nbusy = 0; ndone = 0; nlog = 0;
    start_i = 1'b1;
    for (i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      if (busy_o) begin
        seen = 1;
        if (nlog < 64) ph_log[nlog] = int'(phase_o);
        nlog++; nbusy++;
      end
      if (done_o) ndone++;
      #1 start_i = (i == poke);
      if (i == poke) T0_i = 32'd1;
      if (seen && !busy_o) break;
    end
    if (i == maxc) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: no completion within %0d cycles", maxc);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    if (done_o) ndone++;
    #1;
  endtask

  task automatic wait_for(input int ph, input int cyc, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      if (int'(phase_o) == ph && (cyc < 0 || int'(cycle_cnt_o) == cyc)) break;
      #1 start_i = 1'b0;
    end
    start_i = 1'b0;
    if (i == maxc) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_timeout: phase %0d not reached", ph);
    end
  endtask

  int nb, nd, n_high;
  int base[9] = '{1, 1, 1, 2, 2, 2, 2, 3, 3};

  initial begin
    repeat (2) @(negedge clk_i);
    check("reset_busy", busy_o, 0);
    check("reset_data", data_o, 0);
    check("reset_cnt", cycle_cnt_o, 0);
    #1 rstn_i = 1'b1;
    @(negedge clk_i); #1;

    // Basic run
    T0_i = 3; T2_i = 4; T1_i = 2; reps_i = 2;
    run_to_idle(100, -1, nb, nd);
    check("basic_busy_cycles", nb, 18);
    check("basic_done_count", nd, 1);
    check("basic_cycle_cnt", cycle_cnt_o, 2);
    for (int i = 0; i < 18; i++) check("basic_phase_seq", ph_log[i], base[i % 9]);

    // Zero durations
    T0_i = 0; T1_i = 0; T2_i = 0; reps_i = 3;
    run_to_idle(100, -1, nb, nd);
    check("zero_busy_cycles", nb, 9);
    check("zero_done_count", nd, 1);

    // Config isolation: T0 and start poked mid-run
    T0_i = 4; T1_i = 1; T2_i = 1; reps_i = 2;
    run_to_idle(100, 2, nb, nd);
    n_high = 0;
    for (int i = 0; i < nlog && i < 64; i++) if (ph_log[i] == 1) n_high++;
    check("iso_busy_cycles", nb, 12);
    check("iso_high_cycles", n_high, 8);
    check("iso_done_count", nd, 1);

    // Start together with abort in IDLE
    T0_i = 7; start_i = 1'b1; abort_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("startabort_busy", busy_o, 0);
    check("startabort_cnt_held", cycle_cnt_o, 2);
    #1 start_i = 1'b0; abort_i = 1'b0;

    // Abort in cycle 2 of the second LOW phase
    T0_i = 5; T1_i = 5; T2_i = 5; reps_i = 0;
    start_i = 1'b1;
    wait_for(2, 1, 200);
    @(negedge clk_i);
    #1 abort_i = 1'b1;
    @(negedge clk_i);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_cnt", cycle_cnt_o, 1);
    #1 abort_i = 1'b0;
    @(negedge clk_i);
    check("abort_ind", indicator_o, 0);
    check("abort_done2", done_o, 0);
    check("abort_cnt2", cycle_cnt_o, 1);
    #1;

    // Async reset during RESC
    T0_i = 3; T1_i = 3; T2_i = 3; reps_i = 0;
    start_i = 1'b1;
    wait_for(3, -1, 200);
    #1 rstn_i = 1'b0;
    #1;
    check("areset_phase", phase_o, 0);
    check("areset_busy", busy_o, 0);
    check("areset_data", data_o, 0);
    check("areset_ind", indicator_o, 0);
    check("areset_cnt", cycle_cnt_o, 0);
    check("areset_done", done_o, 0);
    @(negedge clk_i); #1 rstn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("post_reset_idle", busy_o, 0);
    #1;

    // Random traffic against the model
    repeat (3000) begin
      @(negedge clk_i); #1;
      start_i = ($urandom_range(3) == 0);
      abort_i = ($urandom_range(39) == 0);
      if ($urandom_range(7) == 0) begin
        T0_i = $urandom_range(4); T1_i = $urandom_range(4); T2_i = $urandom_range(4);
        reps_i = 16'($urandom_range(3));
      end
    end
    start_i = 1'b0; abort_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("final_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
